// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and the receiver lock-state encoding,
// imported by both the timing generator and the sync receiver.
package vga_timing_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int          CNT_W   = 11;
  localparam logic [10:0] CNT_MAX = 11'd2047;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-register sampler for an active-low sync input with falling-edge detect.
// Both stages reset high so no edge is reported straight out of reset.
module vga_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
    end else begin
      s1_reg <= sync_in;
      s2_reg <= s1_reg;
    end
  end

  assign fall = s2_reg & ~s1_reg;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers active-pixel coordinates from h_sync/v_sync,
// checks line/frame lengths and reports lock and timing-error status.
module vga_sync_receiver #(
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BACK   = vga_timing_pkg::H_BACK,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BACK   = vga_timing_pkg::V_BACK,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pixel_valid,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error,
  output logic [10:0] line_len
);

  import vga_timing_pkg::*;

  localparam logic [11:0] H_START = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
  localparam logic [11:0] V_START = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [11:0] V_TOT   = 12'(V_TOTAL);

  logic [1:0]  sync_vec;
  logic [1:0]  fall_vec;
  logic        hfall;
  logic        vfall;

  logic [23:0] rgb_s1_reg;
  logic [23:0] rgb_s2_reg;

  logic [10:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;
  logic [10:0] len_reg;
  logic        v_pend_reg;
  logic        fs_s2_reg;
  logic        err_s2_reg;

  lock_state_t state_reg;
  lock_state_t state_next;
  logic        err_next;

  logic        fs_evt;
  logic [11:0] h_len;
  logic [11:0] v_len;
  logic        line_ok;
  logic        frame_ok;
  logic        saturated;
  logic        in_window;
  logic [10:0] x_next;
  logic [10:0] y_next;

  assign sync_vec = {v_sync, h_sync};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      vga_sync_edge u_edge (
        .clk     (clk),
        .reset   (reset),
        .sync_in (sync_vec[gi]),
        .fall    (fall_vec[gi])
      );
    end
  endgenerate

  assign hfall = fall_vec[0];
  assign vfall = fall_vec[1];

  // A v_sync fall coinciding with h_sync fall starts the frame on that same line.
  assign fs_evt    = hfall & (v_pend_reg | vfall);
  assign h_len     = {1'b0, h_cnt_reg} + 12'd1;
  assign v_len     = {1'b0, v_cnt_reg} + 12'd1;
  assign line_ok   = (h_len == H_TOT);
  assign frame_ok  = (v_len == V_TOT);
  assign saturated = (h_cnt_reg == CNT_MAX) | (v_cnt_reg == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_s1_reg <= '0;
      rgb_s2_reg <= '0;
    end else begin
      rgb_s1_reg <= {red, green, blue};
      rgb_s2_reg <= rgb_s1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      len_reg    <= '0;
      v_pend_reg <= 1'b0;
      fs_s2_reg  <= 1'b0;
      err_s2_reg <= 1'b0;
      state_reg  <= SEARCH;
    end else begin
      fs_s2_reg  <= fs_evt;
      err_s2_reg <= err_next;
      state_reg  <= state_next;
      if (hfall) begin
        h_cnt_reg <= '0;
        len_reg   <= h_len[10:0];
      end else if (h_cnt_reg != CNT_MAX) begin
        h_cnt_reg <= h_cnt_reg + 11'd1;
      end
      if (fs_evt) begin
        v_cnt_reg  <= '0;
        v_pend_reg <= 1'b0;
      end else begin
        if (hfall && (v_cnt_reg != CNT_MAX)) begin
          v_cnt_reg <= v_cnt_reg + 11'd1;
        end
        if (vfall) begin
          v_pend_reg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (fs_evt) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (fs_evt) begin
          if (frame_ok && line_ok) begin
            state_next = LOCKED;
          end else begin
            state_next = SEARCH;
            err_next   = 1'b1;
          end
        end else if (hfall && !line_ok) begin
          state_next = SEARCH;
          err_next   = 1'b1;
        end
      end
      LOCKED: begin
        if ((hfall && !line_ok) || (fs_evt && !frame_ok) || saturated) begin
          state_next = SEARCH;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  // h_cnt/v_cnt here index the pixel currently held in rgb_s2_reg.
  assign in_window = ({1'b0, h_cnt_reg} >= H_START) && ({1'b0, h_cnt_reg} < H_END) &&
                     ({1'b0, v_cnt_reg} >= V_START) && ({1'b0, v_cnt_reg} < V_END);
  assign x_next    = in_window ? 11'({1'b0, h_cnt_reg} - H_START) : 11'd0;
  assign y_next    = in_window ? 11'({1'b0, v_cnt_reg} - V_START) : 11'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x            <= '0;
      y            <= '0;
      pixel_valid  <= 1'b0;
      red_out      <= '0;
      green_out    <= '0;
      blue_out     <= '0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      line_len     <= '0;
    end else begin
      x            <= x_next;
      y            <= y_next;
      pixel_valid  <= (state_reg == LOCKED) && in_window;
      red_out      <= rgb_s2_reg[23:16];
      green_out    <= rgb_s2_reg[15:8];
      blue_out     <= rgb_s2_reg[7:0];
      frame_start  <= fs_s2_reg;
      locked       <= (state_reg == LOCKED);
      timing_error <= err_s2_reg;
      line_len     <= len_reg;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Frame-level bench for vga_sync_receiver using a scaled-down raster
// (28 clocks x 16 lines) so many frames and corner cases fit in a short run.
module tb_vga_sync_receiver;

  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 16;
  localparam int HT = 28;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 8;
  localparam int VT = 16;
  localparam int FULL = HA * VA;

  typedef struct {
    int nlines;
    int short_idx;
    int shift;
    int exp_err;
    int exp_locked;
    int exp_valid;
    int exp_fs;
    int exp_err_len;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [7:0]  red = '0;
  logic [7:0]  green = '0;
  logic [7:0]  blue = '0;
  logic [10:0] x;
  logic [10:0] y;
  logic        pixel_valid;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        frame_start;
  logic        locked;
  logic        timing_error;
  logic [10:0] line_len;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .x            (x),
    .y            (y),
    .pixel_valid  (pixel_valid),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .frame_start  (frame_start),
    .locked       (locked),
    .timing_error (timing_error),
    .line_len     (line_len)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: running totals sampled on the falling edge.
  int err_pulses = 0;
  int valid_cnt = 0;
  int fs_cnt = 0;
  int coord_bad = 0;
  int data_bad = 0;
  int last_err_len = 0;
  int exp_x = 0;
  int exp_y = 0;

  always @(negedge clk) begin
    if (timing_error) begin
      err_pulses++;
      last_err_len = int'(line_len);
    end
    if (frame_start) begin
      fs_cnt++;
      exp_x = 0;
      exp_y = 0;
    end
    if (pixel_valid) begin
      valid_cnt++;
      if (int'(x) != exp_x || int'(y) != exp_y) coord_bad++;
      if (red_out != x[7:0] || green_out != y[7:0] || blue_out != 8'hA5) data_bad++;
      exp_x++;
      if (exp_x == HA) begin
        exp_x = 0;
        exp_y++;
      end
    end
  end

  int b_err, b_valid, b_fs, b_coord, b_data;
  int prev_shift = 0;
  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    b_err   = err_pulses;
    b_valid = valid_cnt;
    b_fs    = fs_cnt;
    b_coord = coord_bad;
    b_data  = data_bad;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_valid"}, int'(pixel_valid), 0);
    check({tag, "_rgb"}, int'({red_out, green_out, blue_out}), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_terr"}, int'(timing_error), 0);
    check({tag, "_len"}, int'(line_len), 0);
  endtask

  task automatic drive_pixel(input logic hs, input logic vs, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    h_sync = hs;
    v_sync = vs;
    {red, green, blue} = rgb;
  endtask

  // One frame; v.shift > 0 drops v_sync that many clocks before the frame ends,
  // so the next frame start comes from the pending v_sync edge.
  task automatic run_frame(input vec_t v, input string tag, input int rst_line, input int rst_h);
    int len;
    logic vs_low;
    logic [23:0] rgb;
    bit rel;
    rel = 0;
    snap();
    for (int l = 0; l < v.nlines; l++) begin
      len = (l == v.short_idx) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        vs_low = (l < VS - 1) || (l == VS - 1 && h < len - prev_shift) ||
                 (v.shift > 0 && l == v.nlines - 1 && h >= len - v.shift);
        if (h >= HS + HB && h < HS + HB + HA && l >= VS + VB && l < VS + VB + VA)
          rgb = {8'(h - HS - HB), 8'(l - VS - VB), 8'hA5};
        else
          rgb = 24'h0;
        drive_pixel(h >= HS, !vs_low, rgb);
        if (rel) begin
          #1 reset = 1'b1;
          rel = 0;
          snap();
        end
        if (l == rst_line && h == rst_h) begin
          #1 reset = 1'b0;
          #1 check_all_zero({tag, "_rst"});
          rel = 1;
        end
      end
    end
    prev_shift = v.shift;
    check({tag, "_terr_pulses"}, err_pulses - b_err, v.exp_err);
    check({tag, "_locked"}, int'(locked), v.exp_locked);
    check({tag, "_valid_cnt"}, valid_cnt - b_valid, v.exp_valid);
    check({tag, "_fs_cnt"}, fs_cnt - b_fs, v.exp_fs);
    check({tag, "_coord"}, coord_bad - b_coord, 0);
    check({tag, "_data"}, data_bad - b_data, 0);
    if (v.exp_err > 0) check({tag, "_err_line_len"}, last_err_len, v.exp_err_len);
  endtask

  initial begin
    vec_t v;
    // nlines, short_idx, shift, exp_err, exp_locked, exp_valid, exp_fs, exp_err_len
    vecs[0]  = '{VT,     -1, 0, 0, 0, 0,    1, 0};
    vecs[1]  = '{VT,     -1, 0, 0, 1, FULL, 1, 0};
    vecs[2]  = '{VT,     -1, 0, 0, 1, FULL, 1, 0};
    vecs[3]  = '{VT,      6, 0, 1, 0, 2*HA, 1, HT - 1};
    vecs[4]  = '{VT,     -1, 0, 0, 0, 0,    1, 0};
    vecs[5]  = '{VT,     -1, 0, 0, 1, FULL, 1, 0};
    vecs[6]  = '{VT - 1, -1, 0, 0, 1, FULL, 1, 0};
    vecs[7]  = '{VT,     -1, 0, 1, 0, 0,    1, HT};
    vecs[8]  = '{VT,     -1, 5, 0, 0, 0,    1, 0};
    vecs[9]  = '{VT,     -1, 0, 0, 1, FULL, 1, 0};
    vecs[10] = '{VT + 1, -1, 0, 0, 1, FULL, 1, 0};
    vecs[11] = '{VT,     -1, 0, 1, 0, 0,    1, HT};
    vecs[12] = '{VT,     -1, 0, 0, 0, 0,    1, 0};
    vecs[13] = '{VT,     -1, 0, 0, 1, FULL, 1, 0};

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    reset = 1'b1;
    repeat (10) drive_pixel(1'b1, 1'b1, 24'h0);

    for (int i = 0; i < 14; i++) begin
      run_frame(vecs[i], $sformatf("frame%0d", i), -1, -1);
      $display("frame %0d: lines=%0d terr=%0d locked=%0d valid=%0d", i, vecs[i].nlines,
               err_pulses - b_err, locked, valid_cnt - b_valid);
    end

    // h_sync stuck high while locked: counter saturation must drop lock once.
    snap();
    repeat (3000) drive_pixel(1'b1, 1'b1, 24'h0);
    check("stuck_terr_pulses", err_pulses - b_err, 1);
    check("stuck_locked", int'(locked), 0);
    check("stuck_valid_cnt", valid_cnt - b_valid, 0);
    $display("stuck h_sync: terr=%0d locked=%0d", err_pulses - b_err, locked);

    v = '{VT, -1, 0, 0, 0, 0, 1, 0};
    run_frame(v, "relock_a", -1, -1);
    v = '{VT, -1, 0, 0, 1, FULL, 1, 0};
    run_frame(v, "relock_b", -1, -1);
    $display("relock after stuck: locked=%0d", locked);

    // Reset mid-line in a locked frame; lock needs a frame start plus a good frame.
    v = '{VT, -1, 0, 0, 0, 0, 0, 0};
    run_frame(v, "rst_c", 6, 10);
    $display("mid-frame reset: valid after release=%0d", valid_cnt - b_valid);
    v = '{VT, -1, 0, 0, 0, 0, 1, 0};
    run_frame(v, "rst_d", -1, -1);
    v = '{VT, -1, 0, 0, 1, FULL, 1, 0};
    run_frame(v, "rst_e", -1, -1);
    $display("after reset recovery: locked=%0d valid=%0d", locked, valid_cnt - b_valid);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
